led_chain_arbiter: RTL and testbench

- Controller for the 16-LED serial shift chain.
- Shares the chain between two frame requesters using round-robin arbitration.
- Shifts each granted 16-bit frame MSB-first, with the LED data inverted and a divided, gated LED clock.
- Re-sends the last frame periodically when the chain is idle. Sits between user or status logic and the board LED pins.

---
 rtl/led_drv_pkg.sv | 32 +++
 rtl/led_phase_timer.sv | 36 +++
 rtl/led_chain_arbiter.sv | 178 +++++++++++++++++
 tb/tb_led_chain_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_drv_pkg.sv
// Shared types and constants for the LED chain drivers.
package led_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_LO = 2'd1,
    ST_SHIFT_HI = 2'd2,
    ST_DONE     = 2'd3
  } led_state_e;

  localparam logic [1:0] GNT_REQ0    = 2'd0;
  localparam logic [1:0] GNT_REQ1    = 2'd1;
  localparam logic [1:0] GNT_REFRESH = 2'd2;
  localparam logic [1:0] GNT_NONE    = 2'd3;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned BIT_CNT_W  = 5;
  localparam int unsigned DIV_CNT_W  = 8;

  // Round-robin pick between two requesters; refresh only when nobody asks.
  function automatic logic [1:0] rr_pick(input logic req0, input logic req1,
                                         input logic last_grant, input logic refresh_due);
    logic [1:0] sel;
    sel = GNT_NONE;
    if (req0 && req1)     sel = last_grant ? GNT_REQ0 : GNT_REQ1;
    else if (req0)        sel = GNT_REQ0;
    else if (req1)        sel = GNT_REQ1;
    else if (refresh_due) sel = GNT_REFRESH;
    return sel;
  endfunction

endpackage

// File: rtl/led_phase_timer.sv
// Half-period divider: phase_end is high on the last cycle of each CLK_DIV-cycle phase.
module led_phase_timer
  import led_drv_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic phase_end
);

  localparam logic [DIV_CNT_W-1:0] RELOAD = DIV_CNT_W'(CLK_DIV - 1);

  logic [DIV_CNT_W-1:0] r_cnt;
  logic                 r_phase_end;

  // start marks the edge at which a new phase begins; the counter reloads there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_phase_end <= 1'b0;
    end else if (start) begin
      r_cnt       <= RELOAD;
      r_phase_end <= (RELOAD == '0);
    end else if (r_cnt != '0) begin
      r_cnt       <= r_cnt - DIV_CNT_W'(1);
      r_phase_end <= (r_cnt == DIV_CNT_W'(1));
    end else begin
      r_phase_end <= 1'b0;
    end
  end

  assign phase_end = r_phase_end;

endmodule

// File: rtl/led_chain_arbiter.sv
// Round-robin owner of the 16-LED shift chain with idle refresh of the last frame.
module led_chain_arbiter
  import led_drv_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned REFRESH_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic [FRAME_BITS-1:0] data0,
  output logic                  ack0,
  input  logic                  req1,
  input  logic [FRAME_BITS-1:0] data1,
  output logic                  ack1,
  output logic                  busy,
  output logic [1:0]            gnt_id,
  output logic                  frame_done,
  output logic                  LED_CLK,
  output logic                  LED_CLR,
  output logic                  LED_DO,
  output logic                  LED_EN
);

  localparam int unsigned REFRESH_MAX = (REFRESH_CYCLES == 0) ? 0 : REFRESH_CYCLES - 1;
  localparam int unsigned REFRESH_W   = (REFRESH_MAX < 1) ? 1 : $clog2(REFRESH_MAX + 1);
  localparam logic [REFRESH_W-1:0] REFRESH_MAX_C = REFRESH_W'(REFRESH_MAX);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT      = BIT_CNT_W'(FRAME_BITS - 1);

  led_state_e            r_state, w_state_nxt;
  logic [FRAME_BITS-1:0] r_shift, w_shift_nxt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [FRAME_BITS-1:0] r_shadow, w_shadow_nxt;
  logic                  r_last_grant, w_last_grant_nxt;
  logic [REFRESH_W-1:0]  r_refresh_cnt, w_refresh_cnt_nxt;
  logic                  r_ack0, w_ack0_nxt;
  logic                  r_ack1, w_ack1_nxt;
  logic                  r_busy, w_busy_nxt;
  logic [1:0]            r_gnt_id, w_gnt_id_nxt;
  logic                  r_frame_done, w_frame_done_nxt;
  logic                  r_led_clk, w_led_clk_nxt;
  logic                  r_led_do, w_led_do_nxt;
  logic                  r_led_clr;

  logic                  w_start;
  logic                  w_phase_end;
  logic                  w_refresh_due;
  logic [1:0]            w_sel;
  logic [FRAME_BITS-1:0] w_frame;

  led_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .start     (w_start),
    .phase_end (w_phase_end)
  );

  assign w_refresh_due = (REFRESH_CYCLES != 0) && (r_refresh_cnt == REFRESH_MAX_C);
  assign w_sel         = rr_pick(req0, req1, r_last_grant, w_refresh_due);
  assign w_frame       = (w_sel == GNT_REQ0) ? data0 :
                         (w_sel == GNT_REQ1) ? data1 : r_shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_shadow      <= '0;
      r_last_grant  <= 1'b1;
      r_refresh_cnt <= '0;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_busy        <= 1'b0;
      r_gnt_id      <= GNT_NONE;
      r_frame_done  <= 1'b0;
      r_led_clk     <= 1'b1;
      r_led_do      <= 1'b1;
      r_led_clr     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_shift       <= w_shift_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_shadow      <= w_shadow_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_refresh_cnt <= w_refresh_cnt_nxt;
      r_ack0        <= w_ack0_nxt;
      r_ack1        <= w_ack1_nxt;
      r_busy        <= w_busy_nxt;
      r_gnt_id      <= w_gnt_id_nxt;
      r_frame_done  <= w_frame_done_nxt;
      r_led_clk     <= w_led_clk_nxt;
      r_led_do      <= w_led_do_nxt;
      r_led_clr     <= 1'b1;
    end
  end

  // Next-state and next-output logic; LED_DO only moves when a low phase begins.
  always_comb begin
    w_state_nxt       = r_state;
    w_shift_nxt       = r_shift;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_shadow_nxt      = r_shadow;
    w_last_grant_nxt  = r_last_grant;
    w_refresh_cnt_nxt = r_refresh_cnt;
    w_ack0_nxt        = 1'b0;
    w_ack1_nxt        = 1'b0;
    w_busy_nxt        = r_busy;
    w_gnt_id_nxt      = r_gnt_id;
    w_frame_done_nxt  = 1'b0;
    w_led_clk_nxt     = r_led_clk;
    w_led_do_nxt      = r_led_do;
    w_start           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (r_refresh_cnt != REFRESH_MAX_C) w_refresh_cnt_nxt = r_refresh_cnt + REFRESH_W'(1);
        if (w_sel != GNT_NONE) begin
          w_state_nxt   = ST_SHIFT_LO;
          w_start       = 1'b1;
          w_shift_nxt   = w_frame;
          w_shadow_nxt  = w_frame;
          w_bit_cnt_nxt = '0;
          if (w_sel != GNT_REFRESH) w_last_grant_nxt = w_sel[0];
          w_ack0_nxt    = (w_sel == GNT_REQ0);
          w_ack1_nxt    = (w_sel == GNT_REQ1);
          w_busy_nxt    = 1'b1;
          w_gnt_id_nxt  = w_sel;
          w_led_clk_nxt = 1'b0;
          w_led_do_nxt  = ~w_frame[FRAME_BITS-1];
        end
      end
      ST_SHIFT_LO: begin
        if (w_phase_end) begin
          w_state_nxt   = ST_SHIFT_HI;
          w_start       = 1'b1;
          w_led_clk_nxt = 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        if (w_phase_end) begin
          w_shift_nxt   = {r_shift[FRAME_BITS-2:0], 1'b0};
          w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt      = ST_DONE;
            w_frame_done_nxt = 1'b1;
            w_busy_nxt       = 1'b0;
            w_gnt_id_nxt     = GNT_NONE;
            w_led_clk_nxt    = 1'b1;
            w_led_do_nxt     = 1'b1;
          end else begin
            w_state_nxt   = ST_SHIFT_LO;
            w_start       = 1'b1;
            w_led_clk_nxt = 1'b0;
            w_led_do_nxt  = ~r_shift[FRAME_BITS-2];
          end
        end
      end
      ST_DONE: begin
        w_state_nxt       = ST_IDLE;
        w_refresh_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign ack0       = r_ack0;
  assign ack1       = r_ack1;
  assign busy       = r_busy;
  assign gnt_id     = r_gnt_id;
  assign frame_done = r_frame_done;
  assign LED_CLK    = r_led_clk;
  assign LED_CLR    = r_led_clr;
  assign LED_DO     = r_led_do;
  assign LED_EN     = 1'b1;

endmodule

// File: tb/tb_led_chain_arbiter.sv
// Directed and randomized checks of led_chain_arbiter against a frame-level model.
module tb_led_chain_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req0, req1;
  logic [15:0] data0, data1;
  logic        ack0, ack1, busy, frame_done, led_clk, led_clr, led_do, led_en;
  logic [1:0]  gnt_id;

  logic        nr_zero = 1'b0;
  logic [15:0] nr_data = 16'h0;
  logic        nr_ack0, nr_ack1, nr_busy, nr_frame_done, nr_led_clk, nr_led_clr, nr_led_do, nr_led_en;
  logic [1:0]  nr_gnt_id;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level model: who was served last, and what the chain last showed.
  int          m_last   = 1;
  logic [15:0] m_shadow = 16'h0;

  led_chain_arbiter #(.CLK_DIV(2), .REFRESH_CYCLES(50)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .busy(busy), .gnt_id(gnt_id), .frame_done(frame_done),
    .LED_CLK(led_clk), .LED_CLR(led_clr), .LED_DO(led_do), .LED_EN(led_en)
  );

  led_chain_arbiter #(.CLK_DIV(2), .REFRESH_CYCLES(0)) dut_nr (
    .clk(clk), .rst(rst),
    .req0(nr_zero), .data0(nr_data), .ack0(nr_ack0),
    .req1(nr_zero), .data1(nr_data), .ack1(nr_ack1),
    .busy(nr_busy), .gnt_id(nr_gnt_id), .frame_done(nr_frame_done),
    .LED_CLK(nr_led_clk), .LED_CLR(nr_led_clr), .LED_DO(nr_led_do), .LED_EN(nr_led_en)
  );

  int nr_cycles = 0, nr_bad = 0;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      nr_cycles++;
      if (nr_busy !== 1'b0 || nr_led_clk !== 1'b1 || nr_ack0 !== 1'b0 || nr_ack1 !== 1'b0) nr_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_led_clk"}, led_clk, 1);
    check({tag, "_led_do"}, led_do, 1);
    check({tag, "_led_clr"}, led_clr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_gnt_id"}, gnt_id, 3);
    check({tag, "_acks"}, {ack0, ack1, frame_done}, 0);
  endtask

  // Step until a frame starts; no ack or frame_done may appear while waiting.
  task automatic wait_start(input int max, output int lat);
    int stray;
    stray = 0;
    lat   = 0;
    while (busy !== 1'b1 && lat < max) begin
      tick();
      lat++;
      if (frame_done === 1'b1 || (busy !== 1'b1 && (ack0 === 1'b1 || ack1 === 1'b1))) stray++;
    end
    check("start_timeout", busy, 1);
    check("stray_pulse_before_start", stray, 0);
  endtask

  // Walk one whole frame from its first low phase; then sit on the DONE cycle.
  task automatic check_frame(input int exp_id, input logic [15:0] exp_data,
                             input int inj_at, input logic [15:0] inj_data);
    logic [15:0] bits, exp_bits;
    logic        prev_clk, prev_do;
    int          edges, bad;
    bits = '0; edges = 0; bad = 0;
    exp_bits = ~exp_data;
    prev_clk = led_clk;
    prev_do  = led_do;
    for (int i = 0; i < 64; i++) begin
      if (i == inj_at) begin
        req1  = 1'b1;
        data1 = inj_data;
      end
      if (prev_clk === 1'b0 && led_clk === 1'b1) begin
        bits = {bits[14:0], led_do};
        edges++;
        if (led_do !== prev_do) bad++;
      end
      if (i > 0 && (ack0 !== 1'b0 || ack1 !== 1'b0)) bad++;
      if (busy !== 1'b1 || frame_done !== 1'b0 || gnt_id !== 2'(exp_id)) bad++;
      prev_clk = led_clk;
      prev_do  = led_do;
      tick();
    end
    check("frame_bits", bits, exp_bits);
    check("frame_edges", edges, 16);
    check("frame_steady", bad, 0);
    check("done_pulse", frame_done, 1);
    check("done_busy", busy, 0);
    check("done_gnt", gnt_id, 3);
    check("done_led", {led_clk, led_do}, 2'b11);
  endtask

  task automatic serve(input int exp_id, input logic [15:0] exp_data, input int exp_lat,
                       input bit drop, input int inj_at, input logic [15:0] inj_data);
    int lat;
    wait_start(200, lat);
    if (exp_lat >= 0) check("grant_latency", lat, exp_lat);
    check("grant_id", gnt_id, exp_id);
    check("grant_ack", {ack0, ack1}, {exp_id == 0, exp_id == 1});
    if (drop && exp_id == 0) req0 = 1'b0;
    if (drop && exp_id == 1) req1 = 1'b0;
    check_frame(exp_id, exp_data, inj_at, inj_data);
    if (exp_id < 2) begin
      m_last   = exp_id;
      m_shadow = exp_data;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, w;
    bit          p0, p1;
    logic [15:0] d;
    logic [1:0]  r;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    check("reset_led_en", led_en, 1);
    rst = 1'b0;
    check("post_reset_clr_low", led_clr, 0);
    tick();
    check("run_clr_high", led_clr, 1);

    // Basic frame
    req0 = 1'b1; data0 = 16'hA5C3;
    serve(0, 16'hA5C3, 1, 1'b1, -1, '0);
    tick();
    check("idle_after_done", {frame_done, busy}, 0);

    // Round-robin with both requests held
    rst = 1'b1; tick(); rst = 1'b0;
    m_last = 1; m_shadow = '0;
    req0 = 1'b1; req1 = 1'b1; data0 = 16'h0001; data1 = 16'h8000;
    for (int k = 0; k < 4; k++) begin
      w = (m_last == 0) ? 1 : 0;
      serve(w, (w == 1) ? 16'h8000 : 16'h0001, (k == 0) ? 1 : 2, 1'b0, -1, '0);
    end
    req0 = 1'b0; req1 = 1'b0;

    // Request raised mid-frame
    req0 = 1'b1; data0 = 16'($urandom);
    d = 16'($urandom);
    serve(0, data0, 2, 1'b1, int'($urandom_range(5, 60)), d);
    serve(1, d, 2, 1'b1, -1, '0);

    // Randomized request patterns against the round-robin model
    p0 = 1'b0; p1 = 1'b0;
    for (int k = 0; k < 8 || p0 || p1; k++) begin
      if (!p0 && !p1) begin
        r = 2'($urandom_range(1, 3));
        if (r[0]) begin p0 = 1'b1; req0 = 1'b1; data0 = 16'($urandom); end
        if (r[1]) begin p1 = 1'b1; req1 = 1'b1; data1 = 16'($urandom); end
      end
      if (p0 && p1) w = (m_last == 0) ? 1 : 0;
      else          w = p0 ? 0 : 1;
      serve(w, (w == 1) ? data1 : data0, 2, 1'b1, -1, '0);
      if (w == 0) p0 = 1'b0; else p1 = 1'b0;
    end

    // Idle refresh of the last frame, then a request on the expiry cycle
    req0 = 1'b1; data0 = 16'h00FF;
    serve(0, 16'h00FF, 2, 1'b1, -1, '0);
    serve(2, m_shadow, 51, 1'b0, -1, '0);
    repeat (50) tick();
    check("expiry_still_idle", busy, 0);
    req1 = 1'b1; data1 = 16'($urandom);
    serve(1, data1, 1, 1'b1, -1, '0);

    // Reset at bit 7 of a frame
    req0 = 1'b1; data0 = 16'($urandom);
    wait_start(10, lat);
    check("abort_grant", gnt_id, 0);
    req0 = 1'b0;
    repeat (28) tick();
    check("abort_mid_frame", {busy, led_clk}, 2'b10);
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset_outputs("abort");
    m_last = 1; m_shadow = '0;
    serve(2, m_shadow, 50, 1'b0, -1, '0);

    // Refresh-disabled instance stayed quiet throughout
    check("nr_enough_cycles", nr_cycles >= 500, 1);
    check("nr_quiet", nr_bad, 0);
    check("nr_led_clr", nr_led_clr, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
